// File: rtl/invader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : invader_pkg
// Description : Shared types, default geometry and width helpers for the
//               invader formation controller.
// Revision    : 1.0 - initial release
// ============================================================================
package invader_pkg;

    // Formation controller states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MARCH   = 2'd1,
        LANDED  = 2'd2,
        CLEARED = 2'd3
    } formation_state_t;

    // Index width for a range of n values, never narrower than one bit
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Default geometry and the widths derived from it
    localparam int DEF_COLS    = 8;
    localparam int DEF_ROWS    = 3;
    localparam int DEF_FIELD_W = 20;
    localparam int DEF_FIELD_H = 8;
    localparam int DEF_COL_W   = clog2_min1(DEF_COLS);
    localparam int DEF_ROW_W   = clog2_min1(DEF_ROWS);
    localparam int DEF_X_W     = clog2_min1(DEF_FIELD_W);
    localparam int DEF_Y_W     = clog2_min1(DEF_FIELD_H);

endpackage
`default_nettype wire

// File: rtl/invader_extent.sv
`default_nettype none
// ============================================================================
// Module      : invader_extent
// Description : Combinational extent of the alive bitmap: leftmost and
//               rightmost occupied columns, bottom occupied row, any-alive.
// Revision    : 1.0 - initial release
// ============================================================================
module invader_extent
    import invader_pkg::*;
#(
    parameter int COLS = DEF_COLS,
    parameter int ROWS = DEF_ROWS,
    localparam int CW  = clog2_min1(COLS),
    localparam int RW  = clog2_min1(ROWS)
) (
    input  logic [ROWS*COLS-1:0] alive_i,
    output logic [CW-1:0]        lc_o,
    output logic [CW-1:0]        rc_o,
    output logic [RW-1:0]        br_o,
    output logic                 any_alive_o
);

    logic [COLS-1:0] col_any;
    logic [ROWS-1:0] row_any;

    // Fold the bitmap into per-column and per-row occupancy
    always_comb begin
        col_any = '0;
        row_any = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (alive_i[r*COLS+c]) begin
                    col_any[c] = 1'b1;
                    row_any[r] = 1'b1;
                end
            end
        end
    end

    // Priority-pick the outermost occupied column on each side and the bottom row
    always_comb begin
        lc_o = '0;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (col_any[c]) lc_o = CW'(c);
        end
        rc_o = '0;
        for (int c = 0; c < COLS; c++) begin
            if (col_any[c]) rc_o = CW'(c);
        end
        br_o = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (row_any[r]) br_o = RW'(r);
        end
        any_alive_o = |alive_i;
    end

endmodule
`default_nettype wire

// File: rtl/invader_formation.sv
`default_nettype none
// ============================================================================
// Module      : invader_formation
// Description : ROWS x COLS invader formation: alive bitmap, stepped march
//               across a FIELD_W x FIELD_H grid, bullet collision, wave
//               clear and landing detection.
//               Optional macro INVADER_SPEEDUP_EN shortens the step period
//               as invaders are destroyed (registered popcount).
// Revision    : 1.0 - initial release
// ============================================================================
module invader_formation
    import invader_pkg::*;
#(
    parameter int COLS     = 8,
    parameter int ROWS     = 3,
    parameter int FIELD_W  = 20,
    parameter int FIELD_H  = 8,
    parameter int STEP_DIV = 1000000,
    parameter int MIN_DIV  = 100000,
    localparam int XW      = clog2_min1(FIELD_W),
    localparam int YW      = clog2_min1(FIELD_H),
    localparam int CW      = clog2_min1(COLS),
    localparam int RW      = clog2_min1(ROWS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 bullet_valid,
    input  logic [XW-1:0]        bullet_x,
    input  logic [YW-1:0]        bullet_y,
    output logic [ROWS*COLS-1:0] alive,
    output logic [XW-1:0]        pos_x,
    output logic [YW-1:0]        pos_y,
    output logic                 dir,
    output logic                 hit,
    output logic [CW-1:0]        hit_col,
    output logic [RW-1:0]        hit_row,
    output logic                 wave_clear,
    output logic                 landed,
    output logic                 marching
);

    localparam int N  = ROWS * COLS;
    localparam int PW = clog2_min1(STEP_DIV + 1);

    // The speed-up period interpolates between MIN_DIV and STEP_DIV
    if (MIN_DIV < 1 || MIN_DIV > STEP_DIV) begin : g_div_check
        $error("invader_formation: MIN_DIV must lie in 1..STEP_DIV");
    end

    formation_state_t state_q;
    logic [N-1:0]     alive_q;
    logic [XW-1:0]    pos_x_q;
    logic [YW-1:0]    pos_y_q;
    logic             dir_q;
    logic             hit_q;
    logic [CW-1:0]    hit_col_q;
    logic [RW-1:0]    hit_row_q;
    logic             wave_clear_q;
    logic             landed_q;
    logic [PW-1:0]    cnt_q;
    logic [PW-1:0]    cnt_d;
    logic [PW-1:0]    period;

    logic [CW-1:0]    lc;
    logic [CW-1:0]    rc;
    logic [RW-1:0]    br;
    logic             any_alive;

    logic             step_w;
    logic             drop_w;
    logic             land_w;
    logic             hit_w;
    logic             clear_w;
    logic [CW-1:0]    hit_c;
    logic [RW-1:0]    hit_r;
    logic [N-1:0]     hit_mask;
    logic signed [31:0] rel_c;
    logic signed [31:0] rel_r;

    // Edge and landing decisions always look at the pre-clear bitmap
    invader_extent #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_extent (
        .alive_i     (alive_q),
        .lc_o        (lc),
        .rc_o        (rc),
        .br_o        (br),
        .any_alive_o (any_alive)
    );

`ifdef INVADER_SPEEDUP_EN
    localparam int PCW = clog2_min1(N + 1);

    logic [PCW-1:0] popcnt_q;
    logic [PW-1:0]  period_q;
    logic [PW-1:0]  period_d;
    logic [63:0]    scaled;

    // Registered popcount; the period lags the bitmap by one cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) popcnt_q <= '0;
        else        popcnt_q <= PCW'($countones(alive_q));
    end

    // Linear interpolation over the constant formation size
    always_comb begin
        scaled   = 64'(STEP_DIV - MIN_DIV) * 64'(popcnt_q);
        period_d = PW'(64'(MIN_DIV) + scaled / 64'(N));
    end

    // Period only changes at a wrap so a running count is never cut short
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                 period_q <= PW'(STEP_DIV);
        else if (start)             period_q <= PW'(STEP_DIV);
        else if (step_w)            period_q <= period_d;
    end

    assign period = period_q;
`else
    assign period = PW'(STEP_DIV);
`endif

    // Step timing: wrap at period-1 while marching
    always_comb begin
        step_w = (state_q == MARCH) && any_alive && (cnt_q == period - 1'b1);
        cnt_d  = step_w ? '0 : cnt_q + 1'b1;
    end

    // Drop when the outermost live column in the travel direction is at the wall
    always_comb begin
        if (dir_q) drop_w = (32'(pos_x_q) + 32'(lc)) == 32'd0;
        else       drop_w = (32'(pos_x_q) + 32'(rc)) == 32'(FIELD_W - 1);
        land_w = (32'(pos_y_q) + 32'd1 + 32'(br)) == 32'(FIELD_H - 1);
    end

    // Collision against the pre-step position and pre-clear bitmap
    always_comb begin
        hit_w    = 1'b0;
        hit_c    = '0;
        hit_r    = '0;
        hit_mask = '0;
        rel_c    = $signed(32'(bullet_x)) - $signed(32'(pos_x_q));
        rel_r    = $signed(32'(bullet_y)) - $signed(32'(pos_y_q));
        if (state_q == MARCH && bullet_valid) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    if (rel_r == r && rel_c == c && alive_q[r*COLS+c]) begin
                        hit_w              = 1'b1;
                        hit_c              = CW'(c);
                        hit_r              = RW'(r);
                        hit_mask[r*COLS+c] = 1'b1;
                    end
                end
            end
        end
        clear_w = hit_w && ((alive_q & ~hit_mask) == '0);
    end

    // Formation FSM: start reinitialises from any state; clear beats step and landing
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            alive_q      <= '0;
            pos_x_q      <= '0;
            pos_y_q      <= '0;
            dir_q        <= 1'b0;
            hit_q        <= 1'b0;
            hit_col_q    <= '0;
            hit_row_q    <= '0;
            wave_clear_q <= 1'b0;
            landed_q     <= 1'b0;
            cnt_q        <= '0;
        end else begin
            hit_q <= 1'b0;
            if (start) begin
                state_q      <= MARCH;
                alive_q      <= '1;
                pos_x_q      <= '0;
                pos_y_q      <= '0;
                dir_q        <= 1'b0;
                cnt_q        <= '0;
                wave_clear_q <= 1'b0;
                landed_q     <= 1'b0;
            end else begin
                case (state_q)
                    MARCH: begin
                        cnt_q <= cnt_d;
                        if (hit_w) begin
                            alive_q   <= alive_q & ~hit_mask;
                            hit_q     <= 1'b1;
                            hit_col_q <= hit_c;
                            hit_row_q <= hit_r;
                        end
                        if (clear_w) begin
                            state_q      <= CLEARED;
                            wave_clear_q <= 1'b1;
                        end else if (step_w) begin
                            if (drop_w) begin
                                pos_y_q <= pos_y_q + 1'b1;
                                dir_q   <= ~dir_q;
                                if (land_w) begin
                                    state_q  <= LANDED;
                                    landed_q <= 1'b1;
                                end
                            end else if (dir_q) begin
                                pos_x_q <= pos_x_q - 1'b1;
                            end else begin
                                pos_x_q <= pos_x_q + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q <= state_q;
                    end
                endcase
            end
        end
    end

    assign alive      = alive_q;
    assign pos_x      = pos_x_q;
    assign pos_y      = pos_y_q;
    assign dir        = dir_q;
    assign hit        = hit_q;
    assign hit_col    = hit_col_q;
    assign hit_row    = hit_row_q;
    assign wave_clear = wave_clear_q;
    assign landed     = landed_q;
    assign marching   = (state_q == MARCH);

endmodule
`default_nettype wire

// File: tb/tb_invader_formation.sv
`default_nettype none
// ============================================================================
// Module      : tb_invader_formation
// Description : Directed, table-driven bench for invader_formation with a
//               4x2 formation on an 8x4 field, step period 4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_invader_formation;

    localparam int COLS     = 4;
    localparam int ROWS     = 2;
    localparam int FIELD_W  = 8;
    localparam int FIELD_H  = 4;
    localparam int STEP_DIV = 4;
    localparam int MIN_DIV  = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       bullet_valid;
    logic [2:0] bullet_x;
    logic [1:0] bullet_y;
    logic [7:0] alive;
    logic [2:0] pos_x;
    logic [1:0] pos_y;
    logic       dir;
    logic       hit;
    logic [1:0] hit_col;
    logic [0:0] hit_row;
    logic       wave_clear;
    logic       landed;
    logic       marching;

    invader_formation #(
        .COLS     (COLS),
        .ROWS     (ROWS),
        .FIELD_W  (FIELD_W),
        .FIELD_H  (FIELD_H),
        .STEP_DIV (STEP_DIV),
        .MIN_DIV  (MIN_DIV)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .bullet_valid (bullet_valid),
        .bullet_x     (bullet_x),
        .bullet_y     (bullet_y),
        .alive        (alive),
        .pos_x        (pos_x),
        .pos_y        (pos_y),
        .dir          (dir),
        .hit          (hit),
        .hit_col      (hit_col),
        .hit_row      (hit_row),
        .wave_clear   (wave_clear),
        .landed       (landed),
        .marching     (marching)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st;
        logic       bv;
        logic [2:0] bx;
        logic [1:0] by;
        int         n;
        logic [7:0] alive;
        logic [2:0] px;
        logic [1:0] py;
        logic       dir;
        logic       hit;
        logic [1:0] hc;
        logic       hr;
        logic       wc;
        logic       ld;
        logic       mr;
    } vec_t;

    vec_t tbl[$];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic vec_t mk(input logic st, input logic bv, input logic [2:0] bx,
                                input logic [1:0] by, input int n, input logic [7:0] a,
                                input logic [2:0] px, input logic [1:0] py, input logic d,
                                input logic h, input logic [1:0] hc, input logic hr,
                                input logic wc, input logic ld, input logic mr);
        vec_t v;
        v.st = st; v.bv = bv; v.bx = bx; v.by = by; v.n = n;
        v.alive = a; v.px = px; v.py = py; v.dir = d; v.hit = h;
        v.hc = hc; v.hr = hr; v.wc = wc; v.ld = ld; v.mr = mr;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (step %0d): got %0h, want %0h", name, idx, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input int i, input vec_t v);
        chk("alive",      i, 32'(alive),      32'(v.alive));
        chk("pos_x",      i, 32'(pos_x),      32'(v.px));
        chk("pos_y",      i, 32'(pos_y),      32'(v.py));
        chk("dir",        i, 32'(dir),        32'(v.dir));
        chk("hit",        i, 32'(hit),        32'(v.hit));
        chk("hit_col",    i, 32'(hit_col),    32'(v.hc));
        chk("hit_row",    i, 32'(hit_row),    32'(v.hr));
        chk("wave_clear", i, 32'(wave_clear), 32'(v.wc));
        chk("landed",     i, 32'(landed),     32'(v.ld));
        chk("marching",   i, 32'(marching),   32'(v.mr));
    endtask

    initial begin
        // ---- march, landing, start from LANDED, single hits and misses ----
        tbl.push_back(mk(1'b1,1'b0,3'd0,2'd0, 1, 8'hFF,3'd0,2'd0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b1));
        tbl.push_back(mk(1'b0,1'b0,3'd0,2'd0, 4, 8'hFF,3'd1,2'd0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b1));
        tbl.push_back(mk(1'b0,1'b0,3'd0,2'd0,12, 8'hFF,3'd4,2'd0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b1));
        tbl.push_back(mk(1'b0,1'b0,3'd0,2'd0, 4, 8'hFF,3'd4,2'd1,1'b1,1'b0,2'd0,1'b0,1'b0,1'b0,1'b1));
        tbl.push_back(mk(1'b0,1'b0,3'd0,2'd0,16, 8'hFF,3'd0,2'd1,1'b1,1'b0,2'd0,1'b0,1'b0,1'b0,1'b1));
        tbl.push_back(mk(1'b0,1'b0,3'd0,2'd0, 4, 8'hFF,3'd0,2'd2,1'b0,1'b0,2'd0,1'b0,1'b0,1'b1,1'b0));
        tbl.push_back(mk(1'b0,1'b1,3'd0,2'd2, 1, 8'hFF,3'd0,2'd2,1'b0,1'b0,2'd0,1'b0,1'b0,1'b1,1'b0));
        tbl.push_back(mk(1'b1,1'b0,3'd0,2'd0, 1, 8'hFF,3'd0,2'd0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b1));
        tbl.push_back(mk(1'b0,1'b1,3'd2,2'd1, 1, 8'hBF,3'd0,2'd0,1'b0,1'b1,2'd2,1'b1,1'b0,1'b0,1'b1));
        tbl.push_back(mk(1'b0,1'b1,3'd2,2'd1, 1, 8'hBF,3'd0,2'd0,1'b0,1'b0,2'd2,1'b1,1'b0,1'b0,1'b1));
        tbl.push_back(mk(1'b0,1'b1,3'd7,2'd0, 1, 8'hBF,3'd0,2'd0,1'b0,1'b0,2'd2,1'b1,1'b0,1'b0,1'b1));
        tbl.push_back(mk(1'b0,1'b1,3'd2,2'd3, 1, 8'hBF,3'd1,2'd0,1'b0,1'b0,2'd2,1'b1,1'b0,1'b0,1'b1));
        tbl.push_back(mk(1'b0,1'b1,3'd0,2'd0, 1, 8'hBF,3'd1,2'd0,1'b0,1'b0,2'd2,1'b1,1'b0,1'b0,1'b1));
        tbl.push_back(mk(1'b0,1'b1,3'd1,2'd0, 1, 8'hBE,3'd1,2'd0,1'b0,1'b1,2'd0,1'b0,1'b0,1'b0,1'b1));
        // ---- kill column 3: the edge moves in, drop at pos_x=5 ----
        tbl.push_back(mk(1'b1,1'b0,3'd0,2'd0, 1, 8'hFF,3'd0,2'd0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b1));
        tbl.push_back(mk(1'b0,1'b1,3'd3,2'd0, 1, 8'hF7,3'd0,2'd0,1'b0,1'b1,2'd3,1'b0,1'b0,1'b0,1'b1));
        tbl.push_back(mk(1'b0,1'b1,3'd3,2'd1, 1, 8'h77,3'd0,2'd0,1'b0,1'b1,2'd3,1'b1,1'b0,1'b0,1'b1));
        tbl.push_back(mk(1'b0,1'b0,3'd0,2'd0, 2, 8'h77,3'd1,2'd0,1'b0,1'b0,2'd3,1'b1,1'b0,1'b0,1'b1));
        tbl.push_back(mk(1'b0,1'b0,3'd0,2'd0,16, 8'h77,3'd5,2'd0,1'b0,1'b0,2'd3,1'b1,1'b0,1'b0,1'b1));
        tbl.push_back(mk(1'b0,1'b0,3'd0,2'd0, 4, 8'h77,3'd5,2'd1,1'b1,1'b0,2'd3,1'b1,1'b0,1'b0,1'b1));
        // ---- start coincident with a valid hit: start wins ----
        tbl.push_back(mk(1'b1,1'b1,3'd5,2'd1, 1, 8'hFF,3'd0,2'd0,1'b0,1'b0,2'd3,1'b1,1'b0,1'b0,1'b1));
        // ---- clear all eight; step+hit together; last kill on the wrap ----
        tbl.push_back(mk(1'b0,1'b1,3'd0,2'd0, 1, 8'hFE,3'd0,2'd0,1'b0,1'b1,2'd0,1'b0,1'b0,1'b0,1'b1));
        tbl.push_back(mk(1'b0,1'b1,3'd1,2'd0, 1, 8'hFC,3'd0,2'd0,1'b0,1'b1,2'd1,1'b0,1'b0,1'b0,1'b1));
        tbl.push_back(mk(1'b0,1'b1,3'd2,2'd0, 1, 8'hF8,3'd0,2'd0,1'b0,1'b1,2'd2,1'b0,1'b0,1'b0,1'b1));
        tbl.push_back(mk(1'b0,1'b1,3'd3,2'd0, 1, 8'hF0,3'd1,2'd0,1'b0,1'b1,2'd3,1'b0,1'b0,1'b0,1'b1));
        tbl.push_back(mk(1'b0,1'b1,3'd1,2'd1, 1, 8'hE0,3'd1,2'd0,1'b0,1'b1,2'd0,1'b1,1'b0,1'b0,1'b1));
        tbl.push_back(mk(1'b0,1'b1,3'd2,2'd1, 1, 8'hC0,3'd1,2'd0,1'b0,1'b1,2'd1,1'b1,1'b0,1'b0,1'b1));
        tbl.push_back(mk(1'b0,1'b1,3'd3,2'd1, 1, 8'h80,3'd1,2'd0,1'b0,1'b1,2'd2,1'b1,1'b0,1'b0,1'b1));
        tbl.push_back(mk(1'b0,1'b1,3'd4,2'd1, 1, 8'h00,3'd1,2'd0,1'b0,1'b1,2'd3,1'b1,1'b1,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b1,3'd1,2'd1, 4, 8'h00,3'd1,2'd0,1'b0,1'b0,2'd3,1'b1,1'b1,1'b0,1'b0));

        reset        = 1'b0;
        start        = 1'b0;
        bullet_valid = 1'b0;
        bullet_x     = 3'd0;
        bullet_y     = 2'd0;

        // Reset state
        #12;
        check_vec(-1, mk(1'b0,1'b0,3'd0,2'd0,0, 8'h00,3'd0,2'd0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0));
        reset = 1'b1;
        tick();
        chk("idle_holds", -1, 32'(marching), 32'd0);

        // Table
        for (int i = 0; i < tbl.size(); i++) begin
            start        = tbl[i].st;
            bullet_valid = tbl[i].bv;
            bullet_x     = tbl[i].bx;
            bullet_y     = tbl[i].by;
            tick();
            start        = 1'b0;
            bullet_valid = 1'b0;
            for (int k = 1; k < tbl[i].n; k++) tick();
            check_vec(i, tbl[i]);
        end

        // Asynchronous reset in the middle of a march, with a hit pending on the outputs
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        bullet_valid = 1'b1;
        bullet_x     = 3'd3;
        bullet_y     = 2'd1;
        tick();
        bullet_valid = 1'b0;
        chk("pre_reset_hit",   100, 32'(hit),     32'd1);
        chk("pre_reset_alive", 100, 32'(alive),   32'hBF);
        chk("pre_reset_pos_x", 100, 32'(pos_x),   32'd1);
        #2 reset = 1'b0;
        #1;
        check_vec(101, mk(1'b0,1'b0,3'd0,2'd0,0, 8'h00,3'd0,2'd0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0));
        #3 reset = 1'b1;
        bullet_valid = 1'b1;
        bullet_x     = 3'd0;
        bullet_y     = 2'd0;
        tick();
        bullet_valid = 1'b0;
        check_vec(102, mk(1'b0,1'b0,3'd0,2'd0,0, 8'h00,3'd0,2'd0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0));
        start = 1'b1;
        tick();
        start = 1'b0;
        check_vec(103, mk(1'b0,1'b0,3'd0,2'd0,0, 8'hFF,3'd0,2'd0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/invader_formation.md
Name: invader_formation

Overview:
- Parametrised successor to the single-row invader controller: owns a ROWS x COLS alive bitmap, marches the whole formation across a FIELD_W x FIELD_H cell grid, and resolves bullet collisions.
- Sits between the player-bullet logic and the sprite renderer.
- Reports hits, wave-clear and landing to the game-state FSM.

Parameters:
- COLS, 8, invader columns per row.
- ROWS, 3, invader rows.
- FIELD_W, 20, playfield width in cells.
- FIELD_H, 8, playfield height in cells.
- STEP_DIV, 1000000, clk cycles per formation step (base period).
- MIN_DIV, 100000, minimum step period; used only with speed-up.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse: reinitialise the wave and begin marching.
- bullet_valid  in  1  bullet coordinate valid this cycle.
- bullet_x  in  $clog2(FIELD_W)  bullet cell column.
- bullet_y  in  $clog2(FIELD_H)  bullet cell row.
- alive  out  ROWS*COLS  alive bitmap; bit r*COLS+c is row r, column c.
- pos_x  out  $clog2(FIELD_W)  field column of formation column 0.
- pos_y  out  $clog2(FIELD_H)  field row of formation row 0.
- dir  out  1  0 = moving right, 1 = moving left.
- hit  out  1  one-cycle pulse: an invader was destroyed.
- hit_col  out  $clog2(COLS)  column of the destroyed invader; valid with hit.
- hit_row  out  $clog2(ROWS)  row of the destroyed invader; valid with hit.
- wave_clear  out  1  level: all invaders destroyed.
- landed  out  1  level: formation reached the bottom row.
- marching  out  1  level: FSM in MARCH.

Behaviour:
- Reset (reset=0, asynchronous):
  - alive = 0, pos_x = 0, pos_y = 0, dir = 0.
  - hit, hit_col, hit_row, wave_clear, landed = 0.
  - FSM = IDLE, step counter = 0.
- FSM states: IDLE, MARCH, LANDED, CLEARED.
  - Any state, start=1: next cycle alive = all ones, pos_x = 0, pos_y = 0, dir = 0, counter = 0, state = MARCH, wave_clear = 0, landed = 0.
  - IDLE holds until start.
  - LANDED and CLEARED hold until start or reset.
- Step counter (MARCH only):
  - Increments every cycle; on reaching period-1 it wraps to 0 and issues one step.
  - period = STEP_DIV unless the optional feature is enabled.
- Edges use the outermost alive columns, not the fixed grid edge:
  - Lc = lowest column index with any alive bit.
  - Rc = highest column index with any alive bit.
- Step, dir=0:
  - If pos_x+Rc == FIELD_W-1: drop (pos_y+1, dir←1).
  - Otherwise pos_x+1.
- Step, dir=1:
  - If pos_x+Lc == 0: drop (pos_y+1, dir←0).
  - Otherwise pos_x-1.
- A drop never moves horizontally in the same step.
- Landing:
  - Br = highest row index with any alive bit.
  - When a drop makes pos_y+Br == FIELD_H-1: state → LANDED, landed = 1 on the same edge that updates pos_y.
- Collision (MARCH only):
  - Relative cell: c = bullet_x - pos_x, r = bullet_y - pos_y, computed one bit wider, signed.
  - Hit when bullet_valid, 0 ≤ c < COLS, 0 ≤ r < ROWS, and alive[r*COLS+c] = 1.
  - Latency 1: on the next edge, the alive bit is cleared, hit = 1, and hit_col/hit_row = c/r.
  - hit_col/hit_row hold their last value when hit=0.
  - A bullet over a dead cell or outside the grid produces no hit and no change.
- Simultaneous step and hit:
  - The collision uses pre-step pos_x/pos_y and pre-clear alive.
  - Both updates commit on the same edge.
  - Edge and landing decisions for that step use the pre-clear alive.
- Clear:
  - When the bit being cleared is the last alive bit: state → CLEARED, wave_clear = 1 on the same edge. hit still pulses.
  - A step on that edge is discarded.
  - Clear takes priority over landing.
- start coincident with a hit: start wins; hit does not pulse.
- Reset mid-march: immediate return to the reset values above.
- In IDLE, LANDED and CLEARED, bullet_valid is ignored.

Optional Feature:
- Macro: INVADER_SPEEDUP_EN.
- Defined: period = MIN_DIV + ((STEP_DIV-MIN_DIV)*alive_count)/(ROWS*COLS).
  - Evaluated with the constant denominator.
  - alive_count comes from a registered popcount, one cycle stale.
  - A new period takes effect at the next counter wrap; the current count is never truncated.
- Undefined: period = STEP_DIV constant; no popcount logic is instantiated.

Decomposition:
- Package invader_pkg holds:
  - typedef formation_state_t {IDLE, MARCH, LANDED, CLEARED}.
  - Width localparams derived from COLS, ROWS, FIELD_W, FIELD_H.
- One sub-module: invader_extent. Combinational; takes alive and returns Lc, Rc, Br plus an any_alive flag.

Test Plan (COLS=4, ROWS=2, FIELD_W=8, FIELD_H=4, STEP_DIV=4 unless noted):
- Reset low mid-march, then start → alive=8'hFF, pos=(0,0), dir=0, marching=1.
- No bullets → pos_x reaches 4 after 4 steps (16 cycles); 5th step gives pos=(4,1), dir=1; 10th step gives pos=(0,2), landed=1, state LANDED.
- pos=(0,0), bullet (2,1) valid one cycle → next cycle hit=1, hit_col=2, hit_row=1, alive=8'hBF. Same bullet repeated → no hit.
- Bullets at (7,0) and (2,3) with pos=(0,0) → no hit, alive unchanged.
- Kill column 3 in both rows (alive=8'h77), march → drop occurs at pos_x=5, not 4.
- Kill all 8 invaders, the last on a step-wrap cycle → hit=1, wave_clear=1, pos unchanged. With INVADER_SPEEDUP_EN, STEP_DIV=8, MIN_DIV=2, 4 alive → period 5.
